accel_dispatcher: RTL

//  Initiator side of the flow-table accelerator interface. Collects lookup requests
//  (one 32-bit IP per thread) from NUM_THREADS processor threads and arbitrates them

---
 rtl/accel_dispatcher_pkg.sv | 16 +
 rtl/accel_dispatcher_arbiter.sv | 50 +++++
 rtl/accel_dispatcher.sv | 109 ++++++++++
 3 files changed

// File: rtl/accel_dispatcher_pkg.sv
// Shared definitions for the flow-table accelerator dispatcher: thread-state encodings and default sizes.
// No logic. ACC_LATENCY describes the attached accelerator and is used only by benches.
package accel_dispatcher_pkg;

  localparam int DEF_NUM_THREADS = 4;
  localparam int DEF_THREAD_BITS = 2;
  localparam int DEF_NUM_ACTIONS = 4;
  localparam int ACC_LATENCY     = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUED = 2'd1,
    ST_DONE   = 2'd2
  } thread_state_t;

endpackage

// File: rtl/accel_dispatcher_arbiter.sv
// Picks one eligible thread. With DISPATCH_RR_EN: round-robin from ptr. Otherwise: lowest index wins.
// Latency: purely combinational. Backpressure: none; an empty eligible vector yields no grant.
module accel_dispatcher_arbiter
  import accel_dispatcher_pkg::*;
#(
  parameter int NUM_THREADS = DEF_NUM_THREADS,
  parameter int THREAD_BITS = DEF_THREAD_BITS
) (
  input  logic [NUM_THREADS-1:0] eligible,
`ifdef DISPATCH_RR_EN
  input  logic [THREAD_BITS-1:0] ptr,
`endif
  output logic [NUM_THREADS-1:0] grant,
  output logic                   grant_vld,
  output logic [THREAD_BITS-1:0] grant_id
);

`ifdef DISPATCH_RR_EN
  logic [THREAD_BITS-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      idx = THREAD_BITS'((int'(ptr) + i) % NUM_THREADS);
      if (!grant_vld && eligible[idx]) begin
        grant_vld  = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end
`else
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (!grant_vld && eligible[i]) begin
        grant_vld = 1'b1;
        grant[i]  = 1'b1;
        grant_id  = THREAD_BITS'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/accel_dispatcher.sv
// Arbitrates per-thread lookups onto the accelerator and routes results back (DISPATCH_RR_EN selects round-robin).
// Latency: issue registered 1 cycle after grant; result visible the cycle after acc_done.
// Backpressure: one outstanding lookup per thread; ft_busy stalls issue; results are held until resp_ack.
module accel_dispatcher
  import accel_dispatcher_pkg::*;
#(
  parameter int NUM_THREADS = DEF_NUM_THREADS,
  parameter int THREAD_BITS = DEF_THREAD_BITS,
  parameter int NUM_ACTIONS = DEF_NUM_ACTIONS
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_THREADS-1:0]             req_valid,
  input  logic [NUM_THREADS*32-1:0]          req_ip,
  output logic [NUM_THREADS-1:0]             req_ack,
  output logic [NUM_THREADS-1:0]             resp_valid,
  output logic [NUM_THREADS*NUM_ACTIONS-1:0] resp_action,
  output logic [NUM_THREADS-1:0]             resp_match,
  input  logic [NUM_THREADS-1:0]             resp_ack,
  input  logic                               ft_busy,
  output logic                               acc_start,
  output logic [31:0]                        acc_ip,
  output logic [THREAD_BITS-1:0]             acc_thread_id,
  input  logic                               acc_done,
  input  logic [THREAD_BITS-1:0]             acc_thread_id_in,
  input  logic [NUM_ACTIONS-1:0]             acc_action,
  input  logic                               acc_match,
  output logic                               busy,
  output logic                               spurious_err
);

  thread_state_t          state [NUM_THREADS];
  logic [NUM_THREADS-1:0] eligible;
  logic [NUM_THREADS-1:0] done_hit;
  logic [NUM_THREADS-1:0] grant;
  logic                   grant_vld;
  logic [THREAD_BITS-1:0] grant_id;
`ifdef DISPATCH_RR_EN
  logic [THREAD_BITS-1:0] rr_ptr;
`endif

  always_comb begin
    eligible   = '0;
    done_hit   = '0;
    resp_valid = '0;
    busy       = 1'b0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      eligible[t]   = req_valid[t] && (state[t] == ST_IDLE) && !ft_busy;
      done_hit[t]   = acc_done && (state[t] == ST_ISSUED) &&
                      (acc_thread_id_in == THREAD_BITS'(t));
      resp_valid[t] = (state[t] == ST_DONE);
      busy          = busy | (state[t] != ST_IDLE);
    end
  end

  accel_dispatcher_arbiter #(
    .NUM_THREADS (NUM_THREADS),
    .THREAD_BITS (THREAD_BITS)
  ) u_arb (
    .eligible  (eligible),
`ifdef DISPATCH_RR_EN
    .ptr       (rr_ptr),
`endif
    .grant     (grant),
    .grant_vld (grant_vld),
    .grant_id  (grant_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int t = 0; t < NUM_THREADS; t++) state[t] <= ST_IDLE;
      req_ack       <= '0;
      acc_start     <= 1'b0;
      acc_ip        <= '0;
      acc_thread_id <= '0;
      resp_action   <= '0;
      resp_match    <= '0;
      spurious_err  <= 1'b0;
`ifdef DISPATCH_RR_EN
      rr_ptr        <= '0;
`endif
    end else begin
      acc_start <= grant_vld;
      req_ack   <= grant;
      if (grant_vld) begin
        acc_ip        <= req_ip[32*int'(grant_id) +: 32];
        acc_thread_id <= grant_id;
`ifdef DISPATCH_RR_EN
        rr_ptr        <= (int'(grant_id) == NUM_THREADS-1) ? '0 : grant_id + 1'b1;
`endif
      end
      // A completion that matches no ISSUED thread is dropped but remembered.
      if (acc_done && !(|done_hit)) spurious_err <= 1'b1;
      for (int t = 0; t < NUM_THREADS; t++) begin
        case (state[t])
          ST_IDLE:   if (grant[t]) state[t] <= ST_ISSUED;
          ST_ISSUED: if (done_hit[t]) begin
            state[t] <= ST_DONE;
            resp_action[t*NUM_ACTIONS +: NUM_ACTIONS] <= acc_action;
            resp_match[t] <= acc_match;
          end
          ST_DONE:   if (resp_ack[t]) state[t] <= ST_IDLE;
          default:   state[t] <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
